// File: rtl/ram_dp_sync.sv
// Single-clock dual-port RAM: port A read/write with byte lanes, port B read-only.
// Read data and *_rvalid appear READ_LATENCY (1 or 2) cycles after the request edge.
// No backpressure. Requests made while ready is low are dropped. Once ready is high,
// both ports accept one request per cycle.
//
// Ports:
//   clk, reset_n         single clock, asynchronous active-low reset
//   ready                high once the array is usable (after the optional clear)
//   a_en/a_wr/a_be       port A request, write select, byte-lane write enables
//   a_addr/a_din         port A address and write data
//   a_dout/a_rvalid      port A read data and one-cycle valid pulse
//   b_en/b_addr          port B read request and address
//   b_dout/b_rvalid      port B read data and one-cycle valid pulse
//
// FILE names a hex preload image for the memory build flow. The RTL array
// contents are undefined until they are written or cleared.
module ram_dp_sync #(
   parameter int DATA_W         = 8,
   parameter int ADDR_W         = 15,
   parameter int READ_LATENCY   = 1,
   parameter int RDW_MODE       = 0,
   parameter int CLEAR_ON_RESET = 0,
   parameter     FILE           = ""
) (
   input  logic                clk,
   input  logic                reset_n,
   output logic                ready,
   input  logic                a_en,
   input  logic                a_wr,
   input  logic [DATA_W/8-1:0] a_be,
   input  logic [ADDR_W-1:0]   a_addr,
   input  logic [DATA_W-1:0]   a_din,
   output logic [DATA_W-1:0]   a_dout,
   output logic                a_rvalid,
   input  logic                b_en,
   input  logic [ADDR_W-1:0]   b_addr,
   output logic [DATA_W-1:0]   b_dout,
   output logic                b_rvalid
);

   localparam int DEPTH = 2**ADDR_W;
   localparam int NB    = DATA_W/8;

   typedef enum logic [1:0] {ST_RESET, ST_CLEAR, ST_RUN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [ADDR_W-1:0]   clr_addr;
   logic                clr_we;

   logic                a_rd;
   logic                a_we;
   logic                b_rd;

   logic                w_en;
   logic [ADDR_W-1:0]   w_addr;
   logic [DATA_W-1:0]   w_dat;
   logic [NB-1:0]       w_be;

   logic [DATA_W-1:0]   mem [DEPTH];
   logic [DATA_W-1:0]   b_word;

   logic [DATA_W-1:0]   a_d1;
   logic [DATA_W-1:0]   b_d1;
   logic                a_v1;
   logic                b_v1;

   // ---------------- FSM: state register ----------------
   // ready is registered from the next state, so it rises the cycle after
   // the last clear write.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_RESET;
         ready <= 1'b0;
      end else begin
         state <= state_nxt;
         ready <= (state_nxt == ST_RUN);
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         ST_RESET: state_nxt = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
         ST_CLEAR: if (clr_addr == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
         ST_RUN:   state_nxt = ST_RUN;
         default:  state_nxt = ST_RESET;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      clr_we = (state == ST_CLEAR);
   end

   // The clear counter restarts from 0 on every reset, so an aborted clear
   // begins again from the bottom of the array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         clr_addr <= '0;
      end else if (clr_we) begin
         clr_addr <= clr_addr + ADDR_W'(1);
      end
   end

   // ---------------- request qualification ----------------
   assign a_rd = ready & a_en & ~a_wr;
   assign a_we = ready & a_en &  a_wr;
   assign b_rd = ready & b_en;

   // Single write port shared by the clear sequencer and port A. They are never
   // active together because port A is gated by ready.
   always_comb begin
      w_en   = a_we | clr_we;
      w_addr = clr_we ? clr_addr : a_addr;
      w_dat  = clr_we ? '0 : a_din;
      w_be   = clr_we ? {NB{1'b1}} : a_be;
   end

   always_ff @(posedge clk) begin
      if (w_en) begin
         for (int i = 0; i < NB; i++) begin
            if (w_be[i]) mem[w_addr][i*8 +: 8] <= w_dat[i*8 +: 8];
         end
      end
   end

   // Port B read word. In write-first mode, enabled lanes of a same-address
   // port A write are forwarded. Disabled lanes keep the stored (old) bytes.
   always_comb begin
      b_word = mem[b_addr];
      if ((RDW_MODE != 0) && a_we && (a_addr == b_addr)) begin
         for (int i = 0; i < NB; i++) begin
            if (a_be[i]) b_word[i*8 +: 8] = a_din[i*8 +: 8];
         end
      end
   end

   // ---------------- read stage 1 ----------------
   // Data registers load only on an accepted read, so they hold between reads.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         a_d1 <= '0;
         b_d1 <= '0;
         a_v1 <= 1'b0;
         b_v1 <= 1'b0;
      end else begin
         a_v1 <= a_rd;
         b_v1 <= b_rd;
         if (a_rd) a_d1 <= mem[a_addr];
         if (b_rd) b_d1 <= b_word;
      end
   end

   // ---------------- optional read stage 2 ----------------
   if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_W-1:0] a_d2;
      logic [DATA_W-1:0] b_d2;
      logic              a_v2;
      logic              b_v2;

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            a_d2 <= '0;
            b_d2 <= '0;
            a_v2 <= 1'b0;
            b_v2 <= 1'b0;
         end else begin
            a_v2 <= a_v1;
            b_v2 <= b_v1;
            if (a_v1) a_d2 <= a_d1;
            if (b_v1) b_d2 <= b_d1;
         end
      end

      assign a_dout   = a_d2;
      assign a_rvalid = a_v2;
      assign b_dout   = b_d2;
      assign b_rvalid = b_v2;
   end else begin : g_lat1
      assign a_dout   = a_d1;
      assign a_rvalid = a_v1;
      assign b_dout   = b_d1;
      assign b_rvalid = b_v1;
   end

endmodule

// File: tb/tb_ram_dp_sync.sv
// Testbench for ram_dp_sync. Two instances share the same stimulus:
// u_l1 has latency 1 and is read-first; u_l2 has latency 2 and is write-first.
// Both use a 16-bit word, 16 entries, and a clear after reset.
module tb_ram_dp_sync;

   localparam int DW = 16;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          a_en;
   logic          a_wr;
   logic [1:0]    a_be;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_din;
   logic          b_en;
   logic [AW-1:0] b_addr;

   logic          rdy_l1, rdy_l2;
   logic          av_l1, av_l2, bv_l1, bv_l2;
   logic [DW-1:0] ad_l1, ad_l2, bd_l1, bd_l2;

   int cyc = 0;
   int n_tests = 0;
   int n_fail = 0;

   typedef struct {
      logic [DW-1:0] d;
      int            c;
   } exp_t;

   exp_t qa_l1[$];
   exp_t qa_l2[$];
   exp_t qb_l1[$];
   exp_t qb_l2[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ram_dp_sync #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(1), .RDW_MODE(0),
                 .CLEAR_ON_RESET(1), .FILE("")) u_l1 (
      .clk(clk), .reset_n(reset_n), .ready(rdy_l1),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(ad_l1), .a_rvalid(av_l1),
      .b_en(b_en), .b_addr(b_addr), .b_dout(bd_l1), .b_rvalid(bv_l1));

   ram_dp_sync #(.DATA_W(DW), .ADDR_W(AW), .READ_LATENCY(2), .RDW_MODE(1),
                 .CLEAR_ON_RESET(1), .FILE("")) u_l2 (
      .clk(clk), .reset_n(reset_n), .ready(rdy_l2),
      .a_en(a_en), .a_wr(a_wr), .a_be(a_be), .a_addr(a_addr), .a_din(a_din),
      .a_dout(ad_l2), .a_rvalid(av_l2),
      .b_en(b_en), .b_addr(b_addr), .b_dout(bd_l2), .b_rvalid(bv_l2));

   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // The monitor pops one expected response per rvalid pulse and checks both
   // the data and the cycle on which it arrived.
   task automatic mon(input string nm, input logic v, input logic [DW-1:0] d, ref exp_t q[$]);
      exp_t e;
      if (v) begin
         n_tests++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: unexpected rvalid at cycle %0d data %h, expected no pulse", nm, cyc, d);
         end else begin
            e = q.pop_front();
            if (d !== e.d || cyc != e.c) begin
               n_fail++;
               $display("FAIL %s: data %h at cycle %0d, expected %h at cycle %0d", nm, d, cyc, e.d, e.c);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon("a_l1", av_l1, ad_l1, qa_l1);
      mon("a_l2", av_l2, ad_l2, qa_l2);
      mon("b_l1", bv_l1, bd_l1, qb_l1);
      mon("b_l2", bv_l2, bd_l2, qb_l2);
   end

   // Drive one cycle of requests, starting right after a negedge.
   // b_rf is the expected value from the read-first instance.
   // b_wf is the expected value from the write-first instance.
   task automatic drive(input logic ae, input logic aw, input logic [1:0] be,
                        input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                        input logic bn, input logic [AW-1:0] ba,
                        input logic [DW-1:0] a_exp, input logic [DW-1:0] b_rf,
                        input logic [DW-1:0] b_wf);
      a_en = ae; a_wr = aw; a_be = be; a_addr = aa; a_din = ad;
      b_en = bn; b_addr = ba;
      if (ae && !aw) begin
         qa_l1.push_back(exp_t'{a_exp, cyc + 1});
         qa_l2.push_back(exp_t'{a_exp, cyc + 2});
      end
      if (bn) begin
         qb_l1.push_back(exp_t'{b_rf, cyc + 1});
         qb_l2.push_back(exp_t'{b_wf, cyc + 2});
      end
      @(negedge clk);
   endtask

   task automatic wr(input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic [1:0] be);
      drive(1'b1, 1'b1, be, aa, ad, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic rd_a(input logic [AW-1:0] aa, input logic [DW-1:0] e);
      drive(1'b1, 1'b0, 2'b00, aa, '0, 1'b0, '0, e, '0, '0);
   endtask

   task automatic rd_b(input logic [AW-1:0] ba, input logic [DW-1:0] e);
      drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b1, ba, '0, e, e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 2'b00, '0, '0, 1'b0, '0, '0, '0, '0);
   endtask

   task automatic check_zero(input string t);
      check({t, " ready_l1"},  {15'b0, rdy_l1}, '0);
      check({t, " ready_l2"},  {15'b0, rdy_l2}, '0);
      check({t, " a_dout_l1"}, ad_l1, '0);
      check({t, " a_dout_l2"}, ad_l2, '0);
      check({t, " b_dout_l1"}, bd_l1, '0);
      check({t, " b_dout_l2"}, bd_l2, '0);
      check({t, " a_rvalid_l1"}, {15'b0, av_l1}, '0);
      check({t, " a_rvalid_l2"}, {15'b0, av_l2}, '0);
      check({t, " b_rvalid_l1"}, {15'b0, bv_l1}, '0);
      check({t, " b_rvalid_l2"}, {15'b0, bv_l2}, '0);
   endtask

   // Called on the negedge where reset is released. It counts cycles until
   // ready rises. With inject set, it also issues requests that must be
   // dropped while the clear is running: a write of 0xAAAA to address 0
   // (which the clear has already passed) and reads on both ports.
   task automatic wait_ready(input string t, input bit inject);
      int n1 = -1;
      int n2 = -1;
      for (int n = 1; n <= 60 && (n1 < 0 || n2 < 0); n++) begin
         @(negedge clk);
         if (rdy_l1 && n1 < 0) n1 = n;
         if (rdy_l2 && n2 < 0) n2 = n;
         if (inject && n == 5) begin
            a_en = 1'b1; a_wr = 1'b1; a_be = 2'b11; a_addr = '0; a_din = 16'hAAAA;
         end else if (inject && n == 6) begin
            a_en = 1'b1; a_wr = 1'b0; a_addr = 4'd3; b_en = 1'b1; b_addr = 4'd3;
         end else begin
            a_en = 1'b0; a_wr = 1'b0; b_en = 1'b0;
         end
      end
      check({t, " cycles_l1"}, DW'(n1), 16'd17);
      check({t, " cycles_l2"}, DW'(n2), 16'd17);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      a_en = 1'b0; a_wr = 1'b0; a_be = '0; a_addr = '0; a_din = '0;
      b_en = 1'b0; b_addr = '0;
      reset_n = 1'b1;
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check_zero("reset");

      reset_n = 1'b1;
      wait_ready("ready_init", 1'b0);

      // After the clear, every location on B reads back as zero.
      for (int i = 0; i < 16; i++) rd_b(AW'(i), 16'h0000);
      idle(3);

      // Byte-lane merge. A write with no lanes enabled changes nothing.
      wr(4'd3, 16'hBEEF, 2'b11);
      wr(4'd3, 16'h1234, 2'b01);
      rd_a(4'd3, 16'hBE34);
      wr(4'd3, 16'hFFFF, 2'b00);
      rd_a(4'd3, 16'hBE34);

      // Read-during-write on the same address: full word, then low lane only.
      wr(4'd5, 16'h0011, 2'b11);
      drive(1'b1, 1'b1, 2'b11, 4'd5, 16'h0022, 1'b1, 4'd5, '0, 16'h0011, 16'h0022);
      rd_b(4'd5, 16'h0022);
      drive(1'b1, 1'b1, 2'b01, 4'd5, 16'hAB99, 1'b1, 4'd5, '0, 16'h0022, 16'h0099);
      rd_b(4'd5, 16'h0099);

      // Streamed B reads with concurrent A reads to other addresses.
      wr(4'd0, 16'h1000, 2'b11);
      wr(4'd1, 16'h2001, 2'b11);
      wr(4'd2, 16'h3002, 2'b11);
      drive(1'b1, 1'b0, 2'b00, 4'd3, '0, 1'b1, 4'd0, 16'hBE34, 16'h1000, 16'h1000);
      drive(1'b1, 1'b0, 2'b00, 4'd5, '0, 1'b1, 4'd1, 16'h0099, 16'h2001, 16'h2001);
      drive(1'b1, 1'b0, 2'b00, 4'd0, '0, 1'b1, 4'd2, 16'h1000, 16'h3002, 16'h3002);
      idle(4);

      // Outputs hold their last read values.
      check("hold a_dout_l1", ad_l1, 16'h1000);
      check("hold a_dout_l2", ad_l2, 16'h1000);
      check("hold b_dout_l1", bd_l1, 16'h3002);
      check("hold b_dout_l2", bd_l2, 16'h3002);

      // Reset asserted between clock edges takes effect immediately.
      #2 reset_n = 1'b0;
      #1 check_zero("reset_run");
      @(negedge clk);
      reset_n = 1'b1;

      // Abort the clear while it is on address 7.
      repeat (8) @(negedge clk);
      reset_n = 1'b0;
      #1 check_zero("reset_clear");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      wait_ready("ready_restart", 1'b1);

      // Address 0 stays clear (the dropped write), and older data is gone.
      rd_a(4'd0, 16'h0000);
      rd_b(4'd3, 16'h0000);
      rd_b(4'd5, 16'h0000);
      idle(4);

      check("leftover a_l1", DW'(qa_l1.size()), '0);
      check("leftover a_l2", DW'(qa_l2.size()), '0);
      check("leftover b_l1", DW'(qb_l1.size()), '0);
      check("leftover b_l2", DW'(qb_l2.size()), '0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
